// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Purpose:
//   Feeds the configuration-chain head (ccff_head) of the CLB/routing tile
//   column. Bitstream bytes arrive from the host pin interface over a
//   valid/ready handshake. Each byte is serialized MSB-first onto ccff_head.
//   The loader also drives chain_clk_en, which gates the external prog_clk,
//   so the chain advances only on cycles that carry a valid bit. After
//   exactly CHAIN_LEN bits the loader stops and raises done.
//
// Parameters:
//   CHAIN_LEN : total configuration bits in the chain (>= 1)
//   CNT_W     : bit counter width (2**CNT_W must exceed CHAIN_LEN)
//
// Ports:
//   prog_clk     in   the only clock
//   reset        in   synchronous, active-high reset
//   cfg_start    in   one-cycle pulse that starts a load (IDLE or DONE only)
//   din[7:0]     in   bitstream byte; bit 7 is shifted first
//   din_valid    in   din is valid
//   din_ready    out  din is accepted this cycle (high in LOAD)
//   ccff_head    out  registered serial bit into the chain head
//   chain_clk_en out  registered enable for the chain's gated prog_clk
//   ccff_tail    in   serial bit from the chain tail (readback only)
//   busy         out  high in LOAD or SHIFT
//   done         out  high in DONE
//
// Optional readback (macro CCFF_BITSTREAM_LOADER_READBACK_EN):
//   rb_byte[7:0]        out  packed tail bits, first captured bit in bit 7
//   rb_valid            out  one-cycle pulse per emitted rb_byte
//   rb_count[CNT_W-1:0] out  total captured tail bits since cfg_start
//   Without the macro these ports do not exist and ccff_tail is unused.
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             reset,
    input  logic             cfg_start,
    input  logic [7:0]       din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ccff_head,
    output logic             chain_clk_en,
    input  logic             ccff_tail,
    output logic             busy,
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    output logic [7:0]       rb_byte,
    output logic             rb_valid,
    output logic [CNT_W-1:0] rb_count,
`endif
    output logic             done
);

    // Value of the bit counter while the final chain bit is being shifted.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [2:0]       byte_idx;

    logic             start_ok;   // cfg_start honoured this cycle
    logic             take;       // din handshake this cycle

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------------
    // Next state and state-decoded outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        din_ready = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        start_ok  = 1'b0;
        take      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (cfg_start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end

            ST_LOAD: begin
                din_ready = 1'b1;
                busy      = 1'b1;
                if (din_valid) begin
                    take      = 1'b1;
                    state_nxt = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                busy = 1'b1;
                // Chain-full check wins over the end-of-byte return to LOAD,
                // so unused low bits of the final byte are dropped.
                if (bit_cnt == LAST_CNT) begin
                    state_nxt = ST_DONE;
                end else if (byte_idx == 3'd7) begin
                    state_nxt = ST_LOAD;
                end
            end

            ST_DONE: begin
                done = 1'b1;
                if (cfg_start) begin
                    start_ok  = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Serializer datapath
    //
    // ccff_head and chain_clk_en are flopped together from the SHIFT state,
    // so each bit and its enable appear on the same edge, one cycle after
    // the shift cycle that produced them. ccff_head only updates on shift
    // cycles, which holds the last bit through LOAD and DONE.
    // -----------------------------------------------------------------------
    always_ff @(posedge prog_clk) begin
        if (reset) begin
            shreg        <= 8'd0;
            bit_cnt      <= '0;
            byte_idx     <= 3'd0;
            ccff_head    <= 1'b0;
            chain_clk_en <= 1'b0;
        end else begin
            chain_clk_en <= (state == ST_SHIFT);

            if (state == ST_SHIFT) begin
                ccff_head <= shreg[7];
                shreg     <= {shreg[6:0], 1'b0};
                bit_cnt   <= bit_cnt + CNT_W'(1);
                byte_idx  <= byte_idx + 3'd1;
            end

            if (take) begin
                shreg    <= din;
                byte_idx <= 3'd0;
            end

            if (start_ok) begin
                bit_cnt <= '0;
            end
        end
    end

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    // -----------------------------------------------------------------------
    // Readback of the previous configuration
    //
    // The chain shifts on exactly the edges where chain_clk_en is high, so
    // ccff_tail sampled on those edges is the bit leaving the deepest flop.
    // Bits enter rb_shreg LSB-first; after eight of them the first captured
    // bit sits in bit 7. The final enabled edge of a load always happens
    // with the FSM already in DONE, which is where a short last byte is
    // left-justified and flushed.
    // -----------------------------------------------------------------------
    logic [6:0] rb_shreg;
    logic [2:0] rb_bits;
    logic [7:0] rb_cat;

    assign rb_cat = {rb_shreg, ccff_tail};

    always_ff @(posedge prog_clk) begin
        if (reset) begin
            rb_shreg <= 7'd0;
            rb_bits  <= 3'd0;
            rb_byte  <= 8'd0;
            rb_valid <= 1'b0;
            rb_count <= '0;
        end else begin
            rb_valid <= 1'b0;
            // A restart landing on the final enabled edge drops that last
            // tail bit; the new load owns the readback state from here on.
            if (start_ok) begin
                rb_shreg <= 7'd0;
                rb_bits  <= 3'd0;
                rb_count <= '0;
            end else if (chain_clk_en) begin
                rb_shreg <= rb_cat[6:0];
                rb_count <= rb_count + CNT_W'(1);
                if ((rb_bits == 3'd7) || (state == ST_DONE)) begin
                    // Shift the valid low (rb_bits+1) bits to the top; the
                    // vacated low bits fill with zeros.
                    rb_byte  <= rb_cat << (3'd7 - rb_bits);
                    rb_valid <= 1'b1;
                    rb_bits  <= 3'd0;
                end else begin
                    rb_bits <= rb_bits + 3'd1;
                end
            end
        end
    end
`else
    // Without readback the chain tail has no consumer.
    logic unused_ccff_tail;
    assign unused_ccff_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Directed bench for ccff_bitstream_loader. Two instances share clock,
// reset and the host-side inputs: dut_a (CHAIN_LEN=16) and dut_b
// (CHAIN_LEN=12). Each scenario reads the outputs of the instance it
// targets; the other instance just runs alongside. A 16-bit model chain
// sits behind dut_a, clocked by its chain_clk_en, and drives ccff_tail.
// Define CCFF_BITSTREAM_LOADER_READBACK_EN to exercise readback as well.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ccff_bitstream_loader;

    logic        clk;
    logic        reset;
    logic        cfg_start;
    logic [7:0]  din;
    logic        din_valid;

    logic        a_ready, a_head, a_en, a_busy, a_done, a_tail;
    logic        b_ready, b_head, b_en, b_busy, b_done;

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    logic [7:0]  a_rb_byte, b_rb_byte;
    logic        a_rb_valid, b_rb_valid;
    logic [15:0] a_rb_count, b_rb_count;
`endif

    int          checks;
    int          passed;

    // Output selection for the shared load driver.
    logic        sel_b;
    logic        s_ready, s_head, s_en, s_done;

    assign s_ready = sel_b ? b_ready : a_ready;
    assign s_head  = sel_b ? b_head  : a_head;
    assign s_en    = sel_b ? b_en    : a_en;
    assign s_done  = sel_b ? b_done  : a_done;

    // Model chain behind dut_a; bit 15 is the tail.
    logic [15:0] chain_a;
    logic        chain_load;
    logic [15:0] chain_preload;

    always @(posedge clk) begin
        if (chain_load) chain_a <= chain_preload;
        else if (a_en)  chain_a <= {chain_a[14:0], a_head};
    end
    assign a_tail = chain_a[15];

    ccff_bitstream_loader #(.CHAIN_LEN(16), .CNT_W(16)) dut_a (
        .prog_clk     (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (a_ready),
        .ccff_head    (a_head),
        .chain_clk_en (a_en),
        .ccff_tail    (a_tail),
        .busy         (a_busy),
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
        .rb_byte      (a_rb_byte),
        .rb_valid     (a_rb_valid),
        .rb_count     (a_rb_count),
`endif
        .done         (a_done)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(12), .CNT_W(16)) dut_b (
        .prog_clk     (clk),
        .reset        (reset),
        .cfg_start    (cfg_start),
        .din          (din),
        .din_valid    (din_valid),
        .din_ready    (b_ready),
        .ccff_head    (b_head),
        .chain_clk_en (b_en),
        .ccff_tail    (1'b0),
        .busy         (b_busy),
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
        .rb_byte      (b_rb_byte),
        .rb_valid     (b_rb_valid),
        .rb_count     (b_rb_count),
`endif
        .done         (b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    logic [7:0] rb_log [16];
    int         rb_n = 0;
    always @(negedge clk) begin
        if (a_rb_valid && rb_n < 16) begin
            rb_log[rb_n] = a_rb_byte;
            rb_n = rb_n + 1;
        end
    end
`endif

    // -----------------------------------------------------------------------
    // Load driver: pulses cfg_start, offers b0 then b1 (then 0x00) with
    // din_valid high, optionally drops din_valid for 'stall' LOAD cycles
    // after the first byte, and optionally pulses cfg_start again for the
    // edge following observation 'restart_cyc'. Observation cyc=N is taken
    // at the negedge after the N-th rising edge, the first being the edge
    // that samples cfg_start.
    // -----------------------------------------------------------------------
    task automatic run_load(input logic use_b, input logic [7:0] b0,
                            input logic [7:0] b1, input int stall,
                            input int restart_cyc,
                            output logic [31:0] word, output int nen,
                            output int done_cyc, output logic ready_again,
                            output int en_in_stall, output logic done1);
        int   nb;
        int   stall_left;
        int   tail;
        logic hs;
        logic stalled;
        word = 32'd0; nen = 0; done_cyc = 0; ready_again = 1'b0;
        en_in_stall = 0; done1 = 1'b0; nb = 0; stall_left = stall; tail = 0;
        sel_b = use_b;
        @(negedge clk);
        cfg_start = 1'b1;
        din       = b0;
        din_valid = 1'b1;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            hs      = s_ready && din_valid;
            stalled = s_ready && !din_valid;
            @(negedge clk);
            cfg_start = (cyc == restart_cyc);
            if (hs) begin
                nb  = nb + 1;
                din = (nb == 1) ? b1 : 8'h00;
            end
            if (stalled && s_en) en_in_stall++;
            if (s_en) begin
                word = {word[30:0], s_head};
                nen++;
            end
            if (cyc == 1) done1 = s_done;
            if (s_done && done_cyc == 0) done_cyc = cyc;
            if (nb >= 2 && s_ready) ready_again = 1'b1;
            if (nb == 1 && s_ready && stall_left > 0) begin
                din_valid = 1'b0;
                stall_left--;
            end else begin
                din_valid = 1'b1;
            end
            if (done_cyc != 0) begin
                tail++;
                if (tail >= 3) break;
            end
        end
        cfg_start = 1'b0;
        din_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; cfg_start = 1'b0; din = 8'h00; din_valid = 1'b0;
        chain_load = 1'b0; chain_preload = 16'h0000;
        repeat (3) @(negedge clk);
        checks++; if (a_ready !== 1'b0) $display("FAIL reset_din_ready got=%b want=0", a_ready); else passed++;
        checks++; if (a_head !== 1'b0) $display("FAIL reset_ccff_head got=%b want=0", a_head); else passed++;
        checks++; if (a_en !== 1'b0) $display("FAIL reset_chain_clk_en got=%b want=0", a_en); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", a_busy); else passed++;
        checks++; if (a_done !== 1'b0) $display("FAIL reset_done got=%b want=0", a_done); else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [31:0] w; int n, dc, es; logic ra, d1;
        run_load(1'b0, 8'hA5, 8'h3C, 0, 0, w, n, dc, ra, es, d1);
        checks++; if (n !== 16) $display("FAIL basic_enable_count got=%0d want=16", n); else passed++;
        checks++; if (w[15:0] !== 16'hA53C) $display("FAIL basic_bits got=%h want=a53c", w[15:0]); else passed++;
        checks++; if (dc !== 19) $display("FAIL basic_done_cycle got=%0d want=19", dc); else passed++;
        checks++; if (chain_a !== 16'hA53C) $display("FAIL basic_chain_contents got=%h want=a53c", chain_a); else passed++;
        checks++; if (a_done !== 1'b1) $display("FAIL basic_done_held got=%b want=1", a_done); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL basic_busy_in_done got=%b want=0", a_busy); else passed++;
        checks++; if (a_en !== 1'b0) $display("FAIL basic_en_in_done got=%b want=0", a_en); else passed++;
        checks++; if (a_ready !== 1'b0) $display("FAIL basic_ready_in_done got=%b want=0", a_ready); else passed++;
        checks++; if (ra !== 1'b0) $display("FAIL basic_ready_after_last got=%b want=0", ra); else passed++;
    endtask

`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
    task automatic test_readback();
        logic [31:0] w; int n, dc, es, base; logic ra, d1;
        @(negedge clk);
        chain_preload = 16'h1234;
        chain_load    = 1'b1;
        @(negedge clk);
        chain_load    = 1'b0;
        base = rb_n;
        run_load(1'b0, 8'hA5, 8'h3C, 0, 0, w, n, dc, ra, es, d1);
        checks++; if (rb_n - base !== 2) $display("FAIL rb_pulse_count got=%0d want=2", rb_n - base); else passed++;
        checks++; if (rb_log[base] !== 8'h12) $display("FAIL rb_byte0 got=%h want=12", rb_log[base]); else passed++;
        checks++; if (rb_log[base+1] !== 8'h34) $display("FAIL rb_byte1 got=%h want=34", rb_log[base+1]); else passed++;
        checks++; if (a_rb_count !== 16'd16) $display("FAIL rb_count got=%0d want=16", a_rb_count); else passed++;
    endtask
`endif

    task automatic test_stall();
        logic [31:0] w; int n, dc, es; logic ra, d1;
        run_load(1'b0, 8'hA5, 8'h3C, 5, 0, w, n, dc, ra, es, d1);
        checks++; if (es !== 0) $display("FAIL stall_enable_during_stall got=%0d want=0", es); else passed++;
        checks++; if (n !== 16) $display("FAIL stall_enable_count got=%0d want=16", n); else passed++;
        checks++; if (w[15:0] !== 16'hA53C) $display("FAIL stall_bits got=%h want=a53c", w[15:0]); else passed++;
        checks++; if (dc !== 24) $display("FAIL stall_done_cycle got=%0d want=24", dc); else passed++;
    endtask

    task automatic test_start_in_shift();
        logic [31:0] w; int n, dc, es; logic ra, d1;
        run_load(1'b0, 8'h5A, 8'hC3, 0, 5, w, n, dc, ra, es, d1);
        checks++; if (n !== 16) $display("FAIL start_in_shift_count got=%0d want=16", n); else passed++;
        checks++; if (w[15:0] !== 16'h5AC3) $display("FAIL start_in_shift_bits got=%h want=5ac3", w[15:0]); else passed++;
        checks++; if (dc !== 19) $display("FAIL start_in_shift_done_cycle got=%0d want=19", dc); else passed++;
    endtask

    task automatic test_restart_from_done();
        logic [31:0] w; int n, dc, es; logic ra, d1;
        checks++; if (a_done !== 1'b1) $display("FAIL restart_precondition_done got=%b want=1", a_done); else passed++;
        run_load(1'b0, 8'h81, 8'h7E, 0, 0, w, n, dc, ra, es, d1);
        checks++; if (d1 !== 1'b0) $display("FAIL restart_done_cleared got=%b want=0", d1); else passed++;
        checks++; if (w[15:0] !== 16'h817E) $display("FAIL restart_bits got=%h want=817e", w[15:0]); else passed++;
        checks++; if (n !== 16) $display("FAIL restart_enable_count got=%0d want=16", n); else passed++;
        checks++; if (dc !== 19) $display("FAIL restart_done_cycle got=%0d want=19", dc); else passed++;
    endtask

    task automatic test_mid_reset();
        logic [31:0] w; int n, dc, es, seen; logic ra, d1;
        sel_b = 1'b0;
        seen  = 0;
        @(negedge clk);
        cfg_start = 1'b1; din = 8'hFF; din_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && seen < 5; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (a_en) seen++;
        end
        checks++; if (seen !== 5) $display("FAIL mid_reset_reach_bit5 got=%0d want=5", seen); else passed++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; din_valid = 1'b0;
        checks++; if (a_ready !== 1'b0) $display("FAIL mid_reset_din_ready got=%b want=0", a_ready); else passed++;
        checks++; if (a_head !== 1'b0) $display("FAIL mid_reset_ccff_head got=%b want=0", a_head); else passed++;
        checks++; if (a_en !== 1'b0) $display("FAIL mid_reset_chain_clk_en got=%b want=0", a_en); else passed++;
        checks++; if (a_busy !== 1'b0) $display("FAIL mid_reset_busy got=%b want=0", a_busy); else passed++;
        checks++; if (a_done !== 1'b0) $display("FAIL mid_reset_done got=%b want=0", a_done); else passed++;
        run_load(1'b0, 8'hC3, 8'h81, 0, 0, w, n, dc, ra, es, d1);
        checks++; if (w[15:0] !== 16'hC381) $display("FAIL mid_reset_reload_bits got=%h want=c381", w[15:0]); else passed++;
        checks++; if (n !== 16) $display("FAIL mid_reset_reload_count got=%0d want=16", n); else passed++;
    endtask

    task automatic test_partial_byte();
        logic [31:0] w; int n, dc, es; logic ra, d1;
        run_load(1'b1, 8'hFF, 8'h0F, 0, 0, w, n, dc, ra, es, d1);
        checks++; if (n !== 12) $display("FAIL partial_enable_count got=%0d want=12", n); else passed++;
        checks++; if (w[11:0] !== 12'hFF0) $display("FAIL partial_bits got=%h want=ff0", w[11:0]); else passed++;
        checks++; if (dc !== 15) $display("FAIL partial_done_cycle got=%0d want=15", dc); else passed++;
        checks++; if (ra !== 1'b0) $display("FAIL partial_ready_reasserted got=%b want=0", ra); else passed++;
        checks++; if (b_done !== 1'b1 || b_busy !== 1'b0) $display("FAIL partial_end_state got=done%b/busy%b want=done1/busy0", b_done, b_busy); else passed++;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        sel_b  = 1'b0;
        test_reset();
        test_basic();
`ifdef CCFF_BITSTREAM_LOADER_READBACK_EN
        test_readback();
`endif
        test_stall();
        test_start_in_shift();
        test_restart_from_done();
        test_mid_reset();
        test_partial_byte();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
